// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - SAP control sequencer opcodes, control-word layout and T-state constants
package sap_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  // Bit positions within CON; *_N bits are active-low
  typedef enum int {
    CON_LO_N = 0,
    CON_LB_N = 1,
    CON_EU   = 2,
    CON_SU   = 3,
    CON_EA   = 4,
    CON_LA_N = 5,
    CON_EI_N = 6,
    CON_LI_N = 7,
    CON_CE_N = 8,
    CON_LM_N = 9,
    CON_EP   = 10,
    CON_CP   = 11
  } con_bit_e;

  typedef enum logic [5:0] {
    TS_T1 = 6'b000001,
    TS_T2 = 6'b000010,
    TS_T3 = 6'b000100,
    TS_T4 = 6'b001000,
    TS_T5 = 6'b010000,
    TS_T6 = 6'b100000
  } t_state_e;

  localparam logic [11:0] CON_IDLE   = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_LDA_T4 = 12'h1A3;
  localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
  localparam logic [11:0] CON_LDA_T6 = 12'h3E3;
  localparam logic [11:0] CON_ADD_T4 = 12'h1A3;
  localparam logic [11:0] CON_ADD_T5 = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
  localparam logic [11:0] CON_SUB_T4 = 12'h1A3;
  localparam logic [11:0] CON_SUB_T5 = 12'h2E1;
  localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
  localparam logic [11:0] CON_OUT_T4 = 12'h3F2;
  localparam logic [11:0] CON_OUT_T5 = 12'h3E3;
  localparam logic [11:0] CON_OUT_T6 = 12'h3E3;

endpackage

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - one-hot T-state ring, falling-edge stepped, with freeze and recovery
module sap_ring_counter #(
  parameter int WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_freeze,
  output logic [WIDTH-1:0] o_ring
);

  logic [WIDTH-1:0] r_ring;
  logic [WIDTH-1:0] w_first;

  assign w_first = {{(WIDTH-1){1'b0}}, 1'b1};

  // A corrupted (non one-hot) ring restarts at T1 even when frozen
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ring <= w_first;
    end else if (!$onehot(r_ring)) begin
      r_ring <= w_first;
    end else if (!i_freeze) begin
      r_ring <= {r_ring[WIDTH-2:0], r_ring[WIDTH-1]};
    end
  end

  assign o_ring = r_ring;

endmodule

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - SAP T-state sequencing, halt flag and control-word decode
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int T_STATES = 6
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [3:0]          OPCODE,
  output logic [11:0]         CON,
  output logic [T_STATES-1:0] T,
  output logic                HLT
);

  logic [T_STATES-1:0] w_ring;
  logic                w_halt_now;
  logic                r_hlt;
  logic [11:0]         w_con;

  assign w_halt_now = (w_ring == TS_T4) && (OPCODE == OP_HLT);

  sap_ring_counter #(.WIDTH(T_STATES)) u_ring (
    .i_clk    (CLK),
    .i_rst    (CLR),
    .i_freeze (r_hlt | w_halt_now),
    .o_ring   (w_ring)
  );

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      r_hlt <= 1'b0;
    end else if (w_halt_now) begin
      r_hlt <= 1'b1;
    end
  end

  // Reset and halt both force the idle word so no load can fire
  always_comb begin
    w_con = CON_IDLE;
    if (!CLR && !r_hlt) begin
      case (w_ring)
        TS_T1: w_con = CON_T1;
        TS_T2: w_con = CON_T2;
        TS_T3: w_con = CON_T3;
        TS_T4: begin
          case (OPCODE)
            OP_LDA:  w_con = CON_LDA_T4;
            OP_ADD:  w_con = CON_ADD_T4;
            OP_SUB:  w_con = CON_SUB_T4;
            OP_OUT:  w_con = CON_OUT_T4;
            default: w_con = CON_IDLE;
          endcase
        end
        TS_T5: begin
          case (OPCODE)
            OP_LDA:  w_con = CON_LDA_T5;
            OP_ADD:  w_con = CON_ADD_T5;
            OP_SUB:  w_con = CON_SUB_T5;
            OP_OUT:  w_con = CON_OUT_T5;
            default: w_con = CON_IDLE;
          endcase
        end
        TS_T6: begin
          case (OPCODE)
            OP_LDA:  w_con = CON_LDA_T6;
            OP_ADD:  w_con = CON_ADD_T6;
            OP_SUB:  w_con = CON_SUB_T6;
            OP_OUT:  w_con = CON_OUT_T6;
            default: w_con = CON_IDLE;
          endcase
        end
        default: w_con = CON_IDLE;
      endcase
    end
  end

  assign CON = w_con;
  assign T   = w_ring;
  assign HLT = r_hlt;

endmodule
